// File: rtl/fake_psx.sv
// PlayStation controller port master: polls the pad with 01 42 00 00 00 and captures ID/buttons.
// Frame latency ~FRAME_GAP+ATT_SETUP+80*HALF_BIT+ack waits; the bus is host-paced, and the pad throttles only via ack.
module fake_psx #(
    parameter int HALF_BIT    = 1,
    parameter int ATT_SETUP   = 1,
    parameter int ACK_TIMEOUT = 4,
    parameter int FRAME_GAP   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data,
    input  logic        ack,
    output logic        psx_clk,
    output logic        cmd,
    output logic        att,
    output logic [7:0]  pad_id,
    output logic [15:0] buttons,
    output logic        frame_valid,
    output logic        frame_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_BIT_LO, S_BIT_HI, S_ACK_WAIT, S_DONE, S_ABORT
    } state_t;

    localparam logic [7:0] L_GAP   = 8'(FRAME_GAP - 1);
    localparam logic [7:0] L_SETUP = 8'(ATT_SETUP - 1);
    localparam logic [7:0] L_HALF  = 8'(HALF_BIT - 1);
    localparam logic [7:0] L_TMO   = 8'(ACK_TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [2:0]  r_bit, w_bit_nxt;
    logic [2:0]  r_byte, w_byte_nxt;
    logic [7:0]  r_rx, r_b1, r_b2, r_b3;
    logic [7:0]  w_rx_nxt, w_tx;
    logic        w_shift;
    logic        r_ack_s1, r_ack_s2;
    logic        r_psx_clk, r_cmd, r_att, r_frame_valid, r_frame_err;
    logic [7:0]  r_pad_id;
    logic [15:0] r_buttons;

    assign w_rx_nxt = {data, r_rx[7:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 8'd1;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_shift     = 1'b0;
        case (r_state)
            S_IDLE: if (r_cnt == L_GAP) begin
                w_state_nxt = S_SETUP;
                w_cnt_nxt   = '0;
                w_bit_nxt   = '0;
                w_byte_nxt  = '0;
            end
            S_SETUP: if (r_cnt == L_SETUP) begin
                w_state_nxt = S_BIT_LO;
                w_cnt_nxt   = '0;
            end
            S_BIT_LO: if (r_cnt == L_HALF) begin
                w_state_nxt = S_BIT_HI;
                w_cnt_nxt   = '0;
            end
            S_BIT_HI: if (r_cnt == L_HALF) begin
                w_cnt_nxt = '0;
                w_shift   = 1'b1;
                if (r_bit == 3'd7) begin
                    w_bit_nxt   = '0;
                    w_state_nxt = (r_byte == 3'd4) ? S_DONE : S_ACK_WAIT;
                end else begin
                    w_bit_nxt   = r_bit + 3'd1;
                    w_state_nxt = S_BIT_LO;
                end
            end
            S_ACK_WAIT: begin
                // ack wins over a timeout landing on the same cycle
                if (!r_ack_s2) begin
                    w_state_nxt = S_BIT_LO;
                    w_cnt_nxt   = '0;
                    w_byte_nxt  = r_byte + 3'd1;
                end else if (r_cnt == L_TMO) begin
                    w_state_nxt = S_ABORT;
                    w_cnt_nxt   = '0;
                end
            end
            S_DONE, S_ABORT: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_tx = 8'h00;
        case (w_byte_nxt)
            3'd0:    w_tx = 8'h01;
            3'd1:    w_tx = 8'h42;
            default: w_tx = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_byte        <= '0;
            r_rx          <= '0;
            r_b1          <= '0;
            r_b2          <= '0;
            r_b3          <= '0;
            r_ack_s1      <= 1'b1;
            r_ack_s2      <= 1'b1;
            r_psx_clk     <= 1'b1;
            r_cmd         <= 1'b1;
            r_att         <= 1'b1;
            r_pad_id      <= 8'hFF;
            r_buttons     <= 16'hFFFF;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_byte   <= w_byte_nxt;
            r_ack_s1 <= ack;
            r_ack_s2 <= r_ack_s1;
            if (w_shift) begin
                r_rx <= w_rx_nxt;
                if (r_bit == 3'd7) begin
                    case (r_byte)
                        3'd1:    r_b1 <= w_rx_nxt;
                        3'd2:    r_b2 <= w_rx_nxt;
                        3'd3:    r_b3 <= w_rx_nxt;
                        default: ;
                    endcase
                end
            end
            // Outputs follow the next state so they change on the same edge as the FSM
            r_att     <= !(w_state_nxt inside {S_SETUP, S_BIT_LO, S_BIT_HI, S_ACK_WAIT});
            r_psx_clk <= (w_state_nxt != S_BIT_LO);
            r_cmd     <= (w_state_nxt inside {S_BIT_LO, S_BIT_HI}) ? w_tx[w_bit_nxt] : 1'b1;
            r_frame_valid <= (w_state_nxt == S_DONE) && (r_b2 == 8'h5A);
            r_frame_err   <= (w_state_nxt == S_ABORT) ||
                             ((w_state_nxt == S_DONE) && (r_b2 != 8'h5A));
            if ((w_state_nxt == S_DONE) && (r_b2 == 8'h5A)) begin
                r_pad_id  <= r_b1;
                r_buttons <= {w_rx_nxt, r_b3};
            end
        end
    end

    assign psx_clk     = r_psx_clk;
    assign cmd         = r_cmd;
    assign att         = r_att;
    assign pad_id      = r_pad_id;
    assign buttons     = r_buttons;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
endmodule

// File: tb/tb_fake_psx.sv
// Bench for fake_psx: pad model plus scoreboard of per-frame outcomes.
module tb_fake_psx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        data = 1'b1;
    logic        ack = 1'b1;
    logic        psx_clk, cmd, att, frame_valid, frame_err;
    logic [7:0]  pad_id;
    logic [15:0] buttons;

    always #5 clk = ~clk;

    fake_psx dut (
        .clk(clk), .rst_n(rst_n), .data(data), .ack(ack),
        .psx_clk(psx_clk), .cmd(cmd), .att(att),
        .pad_id(pad_id), .buttons(buttons),
        .frame_valid(frame_valid), .frame_err(frame_err)
    );

    typedef struct {
        bit          is_err;
        logic [7:0]  pid;
        logic [15:0] btn;
        int          pulses;
        int          nbytes;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    logic [7:0] reply [5];
    logic [4:0] ack_mask;
    logic [7:0] txexp [5];
    logic [7:0] cmd_cap [5];
    logic [7:0] cmd_sh;
    int bit_cnt = 0, byte_cnt = 0, pulses = 0, ack_cnt = 0;
    logic prev_clk = 1'b1, prev_att = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Pad model: drives data after psx_clk falls, acks bytes selected by ack_mask
    always @(negedge clk) begin
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) ack = 1'b1;
        end
        if (prev_att && !att) begin
            bit_cnt = 0; byte_cnt = 0; pulses = 0;
        end
        if (att) begin
            data = 1'b1;
        end else if (prev_clk && !psx_clk) begin
            pulses++;
            cmd_sh = {cmd, cmd_sh[7:1]};
            if (byte_cnt < 5) data = reply[byte_cnt][bit_cnt];
        end else if (!prev_clk && psx_clk) begin
            bit_cnt++;
            if (bit_cnt == 8) begin
                bit_cnt = 0;
                if (byte_cnt < 5) begin
                    cmd_cap[byte_cnt] = cmd_sh;
                    if (ack_mask[byte_cnt]) begin
                        ack = 1'b0;
                        ack_cnt = 2;
                    end
                end
                byte_cnt++;
            end
        end
        prev_clk = psx_clk;
        prev_att = att;
    end

    // Monitor: every frame-end pulse is matched against the next expected outcome
    always @(negedge clk) begin
        exp_t e;
        if (frame_valid || frame_err) begin
            chk("pulse_exclusive", {31'd0, frame_valid & frame_err}, 32'd0);
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_pulse actual valid=%0b err=%0b required=none", frame_valid, frame_err);
            end else begin
                e = q.pop_front();
                chk("frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
                chk("frame_valid", {31'd0, frame_valid}, {31'd0, !e.is_err});
                chk("pad_id", {24'd0, pad_id}, {24'd0, e.pid});
                chk("buttons", {16'd0, buttons}, {16'd0, e.btn});
                chk("psx_clk_pulses", pulses, e.pulses);
                chk("bytes_done", byte_cnt, e.nbytes);
                for (int i = 0; i < byte_cnt && i < 5; i++)
                    chk($sformatf("cmd_byte%0d", i), {24'd0, cmd_cap[i]}, {24'd0, txexp[i]});
            end
        end
    end

    task automatic set_pad(input logic [39:0] r, input logic [4:0] m);
        for (int i = 0; i < 5; i++) reply[i] = r[8*(4-i) +: 8];
        ack_mask = m;
    endtask

    task automatic push(input bit er, input logic [7:0] p, input logic [15:0] b, input int np, input int nb);
        exp_t e;
        e.is_err = er; e.pid = p; e.btn = b; e.pulses = np; e.nbytes = nb;
        q.push_back(e);
    endtask

    task automatic wait_end(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(frame_valid || frame_err) && n < 3000);
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL %s_timeout actual=no_pulse required=pulse", nm);
        end
        @(negedge clk);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_psx_clk"}, {31'd0, psx_clk}, 32'd1);
        chk({nm, "_cmd"}, {31'd0, cmd}, 32'd1);
        chk({nm, "_att"}, {31'd0, att}, 32'd1);
        chk({nm, "_pad_id"}, {24'd0, pad_id}, 32'hFF);
        chk({nm, "_buttons"}, {16'd0, buttons}, 32'hFFFF);
        chk({nm, "_valid"}, {31'd0, frame_valid}, 32'd0);
        chk({nm, "_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    task automatic att_fall(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (att && n < 100);
        chk(nm, n, 8);
    endtask

    initial begin
        int n;
        txexp[0] = 8'h01; txexp[1] = 8'h42; txexp[2] = 8'h00; txexp[3] = 8'h00; txexp[4] = 8'h00;
        cmd_sh = 8'hFF;
        for (int i = 0; i < 5; i++) cmd_cap[i] = 8'h00;

        set_pad(40'hFF_FF_FF_FF_FF, 5'b00000);
        #1 rst_n = 1'b0;
        #10 check_idle("reset");

        // No pad: one command byte, timeout, error
        push(1'b1, 8'hFF, 16'hFFFF, 8, 1);
        @(negedge clk) rst_n = 1'b1;
        att_fall("att_fall_after_reset");
        wait_end("nopad");

        // Good pad
        set_pad(40'hFF_41_5A_FB_FF, 5'b01111);
        push(1'b0, 8'h41, 16'hFFFB, 40, 5);
        wait_end("good1");

        // Bad marker: outputs hold
        set_pad(40'hFF_73_00_12_34, 5'b01111);
        push(1'b1, 8'h41, 16'hFFFB, 40, 5);
        wait_end("badmark");

        // Good pad, distinct byte3/byte4
        set_pad(40'hFF_73_5A_34_12, 5'b01111);
        push(1'b0, 8'h73, 16'h1234, 40, 5);
        wait_end("good2");

        // Ack only after byte 0: abort after byte 1
        set_pad(40'hFF_41_5A_00_00, 5'b00001);
        push(1'b1, 8'h73, 16'h1234, 16, 2);
        wait_end("abort1");

        // Reset during BIT_LO of bit 3 of byte 0
        set_pad(40'hFF_41_5A_FB_FF, 5'b01111);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(!att && !psx_clk && byte_cnt == 0 && bit_cnt == 3) && n < 500);
        chk("reach_bit3", {31'd0, n < 500}, 32'd1);
        rst_n = 1'b0;
        #1 check_idle("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        att_fall("att_fall_after_midreset");
        push(1'b0, 8'h41, 16'hFFFB, 40, 5);
        wait_end("good3");

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
